hazard_fwd_unit: RTL

Pipeline hazard and forwarding controller for the five-stage MIPS core. It consumes the Execute stage's per-instruction write record: destination address, early write value, Tnew and ALU result. It carries that record through internal M and W stage slots, combines it with load data, and drives the GRF write port. It also supplies forwarded operand values to the D, E and M stages and raises `stall` when a D-stage operand cannot be satisfied by its Tuse deadline.

---
 rtl/hazard_fwd_unit_pkg.sv | 39 +++
 rtl/hazard_fwd_unit_fwd_mux.sv | 33 +++
 rtl/hazard_fwd_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings, slot record type and Tnew/Tuse helpers for the
// hazard/forwarding controller.
package hazard_fwd_unit_pkg;

    localparam int unsigned ADR_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned T_W    = 2;

    localparam logic [T_W-1:0]   T_NONE   = 2'd3;
    localparam logic [T_W-1:0]   T_MAX    = 2'd2;
    localparam logic [ADR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] val;
        logic [T_W-1:0]    tnew;
        logic              ld;
    } slot_t;

    // Clamp a raw Tnew value to the 0..T_MAX range.
    function automatic logic [T_W-1:0] sat_t(input logic [4:0] t);
        return (t > 5'(T_MAX)) ? T_MAX : t[T_W-1:0];
    endfunction

    // A D-stage source must wait while its producer needs longer than its Tuse.
    function automatic logic src_stall(
        input logic [ADR_W-1:0] adr,
        input logic [T_W-1:0]   tuse,
        input logic [ADR_W-1:0] e_adr,
        input logic [T_W-1:0]   e_tnew,
        input logic [ADR_W-1:0] m_adr,
        input logic [T_W-1:0]   m_tnew
    );
        if (adr == REG_ZERO || tuse == T_NONE) return 1'b0;
        return ((adr == e_adr) && (e_tnew > tuse)) ||
               ((adr == m_adr) && (m_tnew > tuse));
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_mux.sv
// Address-match priority selector: youngest ready producer (E, then M,
// then W) wins; register zero always reads the raw value.
module fwd_mux
    import hazard_fwd_unit_pkg::*;
(
    input  logic [ADR_W-1:0]  src_adr,
    input  logic [DATA_W-1:0] raw,
    input  logic [ADR_W-1:0]  e_adr,
    input  logic [DATA_W-1:0] e_val,
    input  logic              e_rdy,
    input  logic [ADR_W-1:0]  m_adr,
    input  logic [DATA_W-1:0] m_val,
    input  logic              m_rdy,
    input  logic [ADR_W-1:0]  w_adr,
    input  logic [DATA_W-1:0] w_val,
    input  logic              w_rdy,
    output logic [DATA_W-1:0] fwd
);

    always_comb begin
        fwd = raw;
        if (src_adr != REG_ZERO) begin
            if (e_rdy && (e_adr == src_adr)) begin
                fwd = e_val;
            end else if (m_rdy && (m_adr == src_adr)) begin
                fwd = m_val;
            end else if (w_rdy && (w_adr == src_adr)) begin
                fwd = w_val;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Five-stage MIPS hazard/forwarding controller: carries the E write record
// through M and W slots, drives the GRF write port, forwards and stalls.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NREG)-1:0]   D_rs_adr,
    input  logic [$clog2(NREG)-1:0]   D_rt_adr,
    input  logic [1:0]                D_tuse_rs,
    input  logic [1:0]                D_tuse_rt,
    input  logic [31:0]               D_rs_reg,
    input  logic [31:0]               D_rt_reg,
    input  logic [$clog2(NREG)-1:0]   E_rs_adr,
    input  logic [$clog2(NREG)-1:0]   E_rt_adr,
    input  logic [31:0]               E_rs_reg,
    input  logic [31:0]               E_rt_reg,
    input  logic [$clog2(NREG)-1:0]   E_regw_adr,
    input  logic [31:0]               E_reg_write,
    input  logic [4:0]                E_T,
    input  logic [31:0]               E_alu_res,
    input  logic [$clog2(NREG)-1:0]   M_rt_adr,
    input  logic [31:0]               M_rt_reg,
    input  logic [31:0]               M_rdata,
    output logic                      stall,
    output logic [31:0]               D_rs_fwd,
    output logic [31:0]               D_rt_fwd,
    output logic [31:0]               E_rs_fwd,
    output logic [31:0]               E_rt_fwd,
    output logic [31:0]               M_rt_fwd,
    output logic                      W_we,
    output logic [$clog2(NREG)-1:0]   W_adr,
    output logic [31:0]               W_data
);

    slot_t m_q, m_d;
    slot_t w_q, w_d;

    logic [T_W-1:0] e_tnew;
    logic           e_rdy;
    logic           m_rdy;

    always_comb begin
        e_tnew = sat_t(E_T);
        e_rdy  = (E_T == 5'd0);
        m_rdy  = (m_q.tnew == 2'd0);

        // Tnew decrements by one per stage, floored at zero.
        m_d.adr  = E_regw_adr;
        m_d.tnew = (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
        m_d.val  = e_rdy ? E_reg_write : E_alu_res;
        m_d.ld   = (e_tnew >= T_MAX);

        w_d.adr  = m_q.adr;
        w_d.val  = m_q.ld ? M_rdata : m_q.val;
        w_d.tnew = 2'd0;
        w_d.ld   = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    always_comb begin
        stall = src_stall(D_rs_adr, D_tuse_rs, E_regw_adr, e_tnew, m_q.adr, m_q.tnew) |
                src_stall(D_rt_adr, D_tuse_rt, E_regw_adr, e_tnew, m_q.adr, m_q.tnew);
        W_we   = (w_q.adr != REG_ZERO);
        W_adr  = w_q.adr;
        W_data = w_q.val;
    end

    fwd_mux u_d_rs (
        .src_adr(D_rs_adr), .raw(D_rs_reg),
        .e_adr(E_regw_adr), .e_val(E_reg_write), .e_rdy(e_rdy),
        .m_adr(m_q.adr),    .m_val(m_q.val),     .m_rdy(m_rdy),
        .w_adr(w_q.adr),    .w_val(w_q.val),     .w_rdy(1'b1),
        .fwd(D_rs_fwd)
    );

    fwd_mux u_d_rt (
        .src_adr(D_rt_adr), .raw(D_rt_reg),
        .e_adr(E_regw_adr), .e_val(E_reg_write), .e_rdy(e_rdy),
        .m_adr(m_q.adr),    .m_val(m_q.val),     .m_rdy(m_rdy),
        .w_adr(w_q.adr),    .w_val(w_q.val),     .w_rdy(1'b1),
        .fwd(D_rt_fwd)
    );

    // E and M consumers cannot take the E-stage early value; that lane is disabled.
    fwd_mux u_e_rs (
        .src_adr(E_rs_adr), .raw(E_rs_reg),
        .e_adr(E_regw_adr), .e_val(E_reg_write), .e_rdy(1'b0),
        .m_adr(m_q.adr),    .m_val(m_q.val),     .m_rdy(m_rdy),
        .w_adr(w_q.adr),    .w_val(w_q.val),     .w_rdy(1'b1),
        .fwd(E_rs_fwd)
    );

    fwd_mux u_e_rt (
        .src_adr(E_rt_adr), .raw(E_rt_reg),
        .e_adr(E_regw_adr), .e_val(E_reg_write), .e_rdy(1'b0),
        .m_adr(m_q.adr),    .m_val(m_q.val),     .m_rdy(m_rdy),
        .w_adr(w_q.adr),    .w_val(w_q.val),     .w_rdy(1'b1),
        .fwd(E_rt_fwd)
    );

    fwd_mux u_m_rt (
        .src_adr(M_rt_adr), .raw(M_rt_reg),
        .e_adr(E_regw_adr), .e_val(E_reg_write), .e_rdy(1'b0),
        .m_adr(m_q.adr),    .m_val(m_q.val),     .m_rdy(1'b0),
        .w_adr(w_q.adr),    .w_val(w_q.val),     .w_rdy(1'b1),
        .fwd(M_rt_fwd)
    );

endmodule
